// File: rtl/gcd_operand_feeder.sv
// gcd_operand_feeder: clocked front end for the combinational GCD block.
// Operand pairs arrive on a valid/ready stream and are queued in a small FIFO.
// Each pair is driven onto X/Y/GcdReset, left to settle for HOLD_CYCLES edges,
// and the sampled gcd_output is then offered downstream with its operands.
// Optional build macro: GCD_FEED_ZERO_CHECK_EN enables the sticky error flag
// (set at capture on a non-zero result under GcdReset, or on a zero operand).
module gcd_operand_feeder #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_x,
    input  logic [7:0] in_y,
    input  logic       in_clear,
    output logic [7:0] X,
    output logic [7:0] Y,
    output logic       GcdReset,
    input  logic [7:0] gcd_output,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_x,
    output logic [7:0] out_y,
    output logic [7:0] out_gcd,
    output logic       err_sticky
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, OUT} state_t;

    state_t            state, state_d;
    logic [16:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [HOLD_W-1:0] hold_cnt;
    logic [16:0]       head;
    logic              push, pop, capture, release_out;

    // Ready is a function of occupancy only, so a full FIFO never accepts,
    // even on a cycle where the head is being popped.
    assign in_ready = (count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    // Next-state and strobe decode for the IDLE -> HOLD -> OUT sequence.
    always_comb begin
        state_d     = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    capture = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_valid && out_ready) begin
                    release_out = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_d;
    end

    // FIFO storage; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr] <= {in_clear, in_x, in_y};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // GCD drive: operands change only on a pop edge and otherwise hold.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            X        <= '0;
            Y        <= '0;
            GcdReset <= 1'b1;
        end else if (pop) begin
            X        <= head[15:8];
            Y        <= head[7:0];
            GcdReset <= head[16];
        end
    end

    // Settle counter: loaded on pop, counts down to the capture edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hold_cnt <= '0;
        end else if (pop) begin
            hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
        end else if (state == HOLD && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Result register: captured once per pair, held until the consumer takes it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_gcd   <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_x     <= X;
            out_y     <= Y;
            out_gcd   <= gcd_output;
        end else if (release_out) begin
            out_valid <= 1'b0;
        end
    end

`ifdef GCD_FEED_ZERO_CHECK_EN
    // Sticky flag for suspicious captures; only Reset clears it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            err_sticky <= 1'b0;
        end else if (capture &&
                     ((GcdReset && gcd_output != '0) || X == '0 || Y == '0)) begin
            err_sticky <= 1'b1;
        end
    end
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Directed bench for gcd_operand_feeder with a behavioural GCD stub on the
// X/Y/GcdReset side and an in-order result scoreboard on the output side.
module tb_gcd_operand_feeder;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_x = '0;
    logic [7:0] in_y = '0;
    logic       in_clear = 1'b0;
    logic [7:0] X, Y;
    logic       GcdReset;
    logic [7:0] gcd_output;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_x, out_y, out_gcd;
    logic       err_sticky;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       clr;
        logic [7:0] g;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] g;
    } exp_t;

    vec_t vecs[13];
    exp_t exp_q[$];

    gcd_operand_feeder #(.DEPTH(4), .HOLD_CYCLES(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_clear(in_clear),
        .X(X), .Y(Y), .GcdReset(GcdReset), .gcd_output(gcd_output),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_gcd(out_gcd),
        .err_sticky(err_sticky)
    );

    always #5 Clock = ~Clock;

    // Behavioural GCD block: 0 under reset or when either operand is 0.
    function automatic logic [7:0] gcd_fn(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, t;
        a = a_in;
        b = b_in;
        for (int k = 0; k < 16; k++) begin
            if (b != 0) begin
                t = a % b;
                a = b;
                b = t;
            end
        end
        return a;
    endfunction

    always_comb begin
        gcd_output = 8'd0;
        if (!GcdReset && X != 0 && Y != 0) gcd_output = gcd_fn(X, Y);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Result scoreboard: a handshake will occur at the next rising edge.
    always @(negedge Clock) begin
        if (!Reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_x", out_x, e.x);
                check("res_y", out_y, e.y);
                check("res_gcd", out_gcd, e.g);
            end
        end
    end

    // Offer one vector for a single handshake, bounded wait on in_ready.
    task automatic push_vec(input int i);
        int n;
        in_valid = 1'b1;
        in_x     = vecs[i].x;
        in_y     = vecs[i].y;
        in_clear = vecs[i].clr;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("push_timeout", 0, 1);
        else exp_q.push_back('{vecs[i].x, vecs[i].y, vecs[i].g});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        int accepted;
        int idx;
        vecs[0]  = '{8'd12,  8'd3,   1'b0, 8'd3};
        vecs[1]  = '{8'd28,  8'd5,   1'b0, 8'd1};
        vecs[2]  = '{8'd5,   8'd28,  1'b0, 8'd1};
        vecs[3]  = '{8'd192, 8'd3,   1'b0, 8'd3};
        vecs[4]  = '{8'd12,  8'd6,   1'b1, 8'd0};
        vecs[5]  = '{8'd12,  8'd8,   1'b0, 8'd4};
        vecs[6]  = '{8'd9,   8'd6,   1'b0, 8'd3};
        vecs[7]  = '{8'd15,  8'd10,  1'b0, 8'd5};
        vecs[8]  = '{8'd14,  8'd21,  1'b0, 8'd7};
        vecs[9]  = '{8'd7,   8'd5,   1'b0, 8'd1};
        vecs[10] = '{8'd100, 8'd75,  1'b0, 8'd25};
        vecs[11] = '{8'd0,   8'd192, 1'b0, 8'd0};
        vecs[12] = '{8'd0,   8'd0,   1'b0, 8'd0};

        // Reset state
        repeat (3) tick();
        check("rst_X", X, 0);
        check("rst_Y", Y, 0);
        check("rst_GcdReset", GcdReset, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_gcd", out_gcd, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_err", err_sticky, 0);
        Reset = 1'b0;
        tick();

        // 1: single pair, latency from pop edge
        push_vec(0);
        check("t1_X_before_pop", X, 0);
        tick();
        check("t1_X", X, 12);
        check("t1_Y", Y, 3);
        check("t1_GcdReset", GcdReset, 0);
        check("t1_valid_e0", out_valid, 0);
        tick();
        check("t1_valid_e1", out_valid, 0);
        tick();
        check("t1_valid_e2", out_valid, 1);
        check("t1_gcd", out_gcd, 3);
        check("t1_out_x", out_x, 12);
        check("t1_out_y", out_y, 3);
        tick();
        check("t1_valid_after_hs", out_valid, 0);
        wait_drain();

        // 2: back-to-back pairs
        for (int i = 1; i <= 3; i++) begin
            check("t2_in_ready", in_ready, 1);
            push_vec(i);
        end
        wait_drain();

        // 3: clear request forces a zero result
        push_vec(4);
        tick();
        check("t3_GcdReset_pop", GcdReset, 1);
        tick();
        check("t3_GcdReset_hold", GcdReset, 1);
        wait_drain();
        check("t3_err", err_sticky, 0);

        // 4: stalled consumer, six pairs offered
        out_ready = 1'b0;
        accepted = 0;
        idx = 5;
        for (int c = 0; c < 12; c++) begin
            if (idx <= 10) begin
                in_valid = 1'b1;
                in_x     = vecs[idx].x;
                in_y     = vecs[idx].y;
                in_clear = vecs[idx].clr;
                if (in_ready) begin
                    exp_q.push_back('{vecs[idx].x, vecs[idx].y, vecs[idx].g});
                    accepted++;
                    idx++;
                end
            end
            tick();
        end
        check("t4_accepted", accepted, 5);
        check("t4_in_ready_full", in_ready, 0);
        in_valid = 1'b0;
        check("t4_valid", out_valid, 1);
        check("t4_gcd", out_gcd, 4);
        repeat (3) tick();
        check("t4_valid_held", out_valid, 1);
        check("t4_gcd_held", out_gcd, 4);
        check("t4_x_held", out_x, 12);
        out_ready = 1'b1;
        wait_drain();

        // 5: zero operands, X/Y move only on pop edges
        push_vec(11);
        check("t5_X_prepop", X, 7);
        check("t5_Y_prepop", Y, 5);
        push_vec(12);
        check("t5_X_pop1", X, 0);
        check("t5_Y_pop1", Y, 192);
        repeat (3) tick();
        check("t5_Y_held", Y, 192);
        tick();
        check("t5_Y_pop2", Y, 0);
        wait_drain();
`ifdef GCD_FEED_ZERO_CHECK_EN
        check("t5_err", err_sticky, 1);
`else
        check("t5_err", err_sticky, 0);
`endif

        // 6: reset during HOLD with pairs queued
        out_ready = 1'b0;
        push_vec(5);
        push_vec(6);
        push_vec(7);
        check("t6_valid_pre", out_valid, 0);
        check("t6_X_pre", X, 12);
        Reset = 1'b1;
        #1;
        exp_q.delete();
        check("t6_valid", out_valid, 0);
        check("t6_GcdReset", GcdReset, 1);
        check("t6_X", X, 0);
        check("t6_Y", Y, 0);
        check("t6_err", err_sticky, 0);
        tick();
        Reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t6_no_stale_valid", out_valid, 0);
            check("t6_no_pop", X, 0);
        end
        check("t6_in_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gcd_operand_feeder.md
Name: gcd_operand_feeder

Overview:
Clocked upstream stage for the combinational GCD block. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It drives one pair at a time onto the GCD block's X, Y and Reset inputs, waits a fixed settle interval, then samples gcd_output. The captured result is presented downstream with the operands on a valid/ready stream.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, >= 2
HOLD_CYCLES, 2, clock edges from operand drive to result capture; >= 1

Ports:
Clock  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  FIFO can accept a pair
in_x  input  8  operand X
in_y  input  8  operand Y
in_clear  input  1  request a GCD reset for this pair (result forced 0)
X  output  8  drives GCD X
Y  output  8  drives GCD Y
GcdReset  output  1  drives GCD Reset
gcd_output  input  8  GCD result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_x  output  8  X of the captured pair
out_y  output  8  Y of the captured pair
out_gcd  output  8  captured gcd_output
err_sticky  output  1  see Optional Feature

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. The clock port is Clock and the reset port is Reset.
- Reset values: FIFO empty, state IDLE, X=0, Y=0, GcdReset=1, out_valid=0, out_x=0, out_y=0, out_gcd=0, err_sticky=0. Assertion of Reset mid-operation discards the FIFO contents and any in-flight pair at once.
- FIFO: 17-bit entries {clear,x,y}. Uses a count register with ptr width log2(DEPTH) and natural pointer wrap.
  - in_ready = (count < DEPTH). It depends only on count, so a push is not accepted when full, even if a pop happens in the same cycle.
  - Push occurs when in_valid && in_ready. A simultaneous push and pop leaves count unchanged.
- FSM, states IDLE, HOLD, OUT:
  - IDLE: if the FIFO is non-empty, pop the head. On that edge, register X<=x, Y<=y, GcdReset<=clear and hold_cnt<=HOLD_CYCLES-1, then go to HOLD. If the FIFO is empty, stay in IDLE.
  - HOLD: if hold_cnt != 0, decrement it. If hold_cnt == 0, on that edge capture out_gcd<=gcd_output, out_x<=X, out_y<=Y, set out_valid<=1 and go to OUT.
  - OUT: out_valid, out_x, out_y and out_gcd stay stable while out_ready=0. When out_valid && out_ready, clear out_valid and go to IDLE. The next pop occurs no earlier than the following cycle.
- Latency: the pop edge to out_valid high is exactly HOLD_CYCLES edges. Minimum throughput is one result per HOLD_CYCLES+2 cycles.
- X, Y and GcdReset keep their last driven values in IDLE and OUT; they are never returned to 0 between pairs. They change only on a pop edge.
- No arithmetic is done here; widths are passed straight through. Operand value 0 is legal and is forwarded unchanged.

Optional Feature:
Macro: GCD_FEED_ZERO_CHECK_EN.
- Defined: at the capture edge, err_sticky is set if gcd_output != 0 while GcdReset==1, or X==0, or Y==0. err_sticky clears only on Reset.
- Undefined: err_sticky is tied to 0 and no check logic is built.

Test Plan:
1. Push (12,3,clear=0) with out_ready=1 -> X=12, Y=3 after the pop edge. out_valid rises 2 edges later with out_gcd=3, out_x=12, out_y=3.
2. Back-to-back push of (28,5,0), (5,28,0), (192,3,0) -> three results in order with out_gcd 1, 1, 3. in_ready stays 1.
3. Push (12,6,clear=1) -> GcdReset=1 during HOLD and out_gcd=0. With the macro defined, err_sticky stays 0 and drops the error flag would stay clear.
4. out_ready=0 while 6 pairs are offered -> exactly 5 are accepted (1 in flight plus 4 queued). in_ready is 0 on the 6th, and out_valid/out_gcd are held stable.
5. Push (0,192,0) then (0,0,0) -> out_gcd=0 for both, and X/Y change only on pop edges.
6. Assert Reset during HOLD with 2 pairs queued -> out_valid=0, GcdReset=1, X=Y=0, count=0. After release, no stale result appears.
